boid_raster_writer: RTL
=======================

BOID_RASTER_WRITER -- requirements
Module: boid_raster_writer

Interface
REQ-001 SHALL have parameter MAX_BOIDS, default 16: number of boid position slots; power of two, 2..256.
REQ-002 SHALL have parameter VIDEO_WIDTH, default 640: screen width in pixels.
REQ-003 SHALL have parameter VIDEO_HEIGHT, default 480: screen height in pixels.
REQ-004 SHALL have parameter SPRITE_SIZE, default 2: side length of the square drawn per boid; 1..4.
REQ-005 SHALL have derived constants BOID_W = clog2(MAX_BOIDS) and ADDR_W = clog2(VIDEO_WIDTH*VIDEO_HEIGHT)+1.
REQ-006 SHALL have port clock, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port cpu_we, input, 1: CPU position write strobe.
REQ-009 SHALL have port cpu_sel, input, BOID_W: target boid slot.
REQ-010 SHALL have port cpu_x, input, 10: boid x, in pixels.
REQ-011 SHALL have port cpu_y, input, 9: boid y, in pixels.
REQ-012 SHALL have port frame_end, input, 1: one-cycle pulse from the VGA controller at end of screen.
REQ-013 SHALL have port wr_en, output, 1: display RAM write enable.
REQ-014 SHALL have port wr_addr, output, ADDR_W: display RAM write address.
REQ-015 SHALL have port clear_req, output, 1: one-cycle pulse that clears the draw buffer.
REQ-016 SHALL have port buf_sel, output, 1: buffer the VGA reads; writes target ~buf_sel.
REQ-017 SHALL have port busy, output, 1: high from CLEAR through DONE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when drawing completes.
REQ-019 SHALL have port overrun, output, 1: sticky flag for a frame_end lost while busy.

Function
REQ-020 SHALL hold a live table of MAX_BOIDS {x,y} entries.
- cpu_we writes entry cpu_sel at the clock edge.
- CPU writes SHALL be accepted in every state.
REQ-021 SHALL use a state machine with states IDLE, CLEAR, DRAW, DONE.
- IDLE->CLEAR on frame_end.
- CLEAR->DRAW after 1 cycle.
- DRAW->DONE after the last pixel.
- DONE->IDLE after 1 cycle.
REQ-022 SHALL, on the edge where IDLE samples frame_end, do all of the following:
- copy the live table into a shadow table, including any same-edge CPU write (the new value wins);
- toggle buf_sel.
REQ-023 SHALL assert clear_req for exactly the CLEAR cycle, with wr_en=0 in that cycle.
REQ-024 SHALL, in DRAW, iterate one pixel per cycle over the shadow table only.
- Order: boid index outer (0..MAX_BOIDS-1), then dy, then dx innermost (each 0..SPRITE_SIZE-1).
- Duration: exactly MAX_BOIDS*SPRITE_SIZE^2 cycles.
REQ-025 SHALL set wr_addr=(y+dy)*VIDEO_WIDTH+(x+dx), with the arithmetic done at ADDR_W bits without truncation.
REQ-026 SHALL drive wr_en=1 only when x+dx<VIDEO_WIDTH and y+dy<VIDEO_HEIGHT.
- A clipped pixel still consumes its cycle, with wr_en=0.
- wr_addr is don't-care while wr_en=0.
REQ-027 SHALL register wr_en and wr_addr: the pixel for a DRAW cycle appears on the outputs in that same cycle, i.e. the first write is the cycle after clear_req.
REQ-028 SHALL assert done for the DONE cycle only, and drop busy in the cycle after DONE.
REQ-029 SHALL handle frame_end outside IDLE as follows:
- ignore it for sequencing;
- set overrun;
- leave buf_sel and the shadow table unchanged.
- overrun clears only on reset.
REQ-030 SHALL let a CPU write during DRAW affect only the next frame.

Reset
REQ-031 SHALL, on asynchronous reset assertion, immediately go to IDLE, including mid-operation.
- Outputs wr_en, clear_req, busy, done, overrun, buf_sel SHALL be 0.
- wr_addr, both tables and all counters SHALL be 0.
REQ-032 SHALL require the first frame_end after reset release to start a normal sequence.

Structure
REQ-033 SHALL take VIDEO_WIDTH, VIDEO_HEIGHT and the FSM state encoding from shared package boid_pkg.
REQ-034 SHALL instantiate one sub-module, boid_addr_calc: combinational x, y, dx, dy -> {in_bounds, addr}.

Verification
REQ-035 SHALL include these directed scenarios (MAX_BOIDS=4, SPRITE_SIZE=2, 640x480 unless stated):
- Release reset, no stimulus -> all outputs 0 for 20 cycles.
- Write boid0=(10,20), boids1..3=(0,0), frame_end at T ->
  - clear_req at T+1, buf_sel=1;
  - T+2..T+5: writes to 12810, 12811, 13450, 13451;
  - done at T+18, busy low at T+19.
- Boid0=(639,479) -> only address 307199 is written; the other 3 pixel cycles of boid0 have wr_en=0.
- frame_end while in DRAW -> overrun=1, buf_sel unchanged, write count for the frame still 16.
- Write boid0=(100,100) during DRAW after (10,20) was snapshotted -> current frame writes 12810; next frame writes 64100.
- Assert reset at T+6 of a draw -> wr_en=0 and busy=0 immediately, buf_sel=0; the next frame_end yields a full 16-pixel sequence.

Source files
------------

// File: rtl/boid_pkg.sv
// rtl/boid_pkg.sv - shared video geometry and draw FSM state encoding
package boid_pkg;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/boid_addr_calc.sv
// rtl/boid_addr_calc.sv - sprite pixel to display RAM address with screen clipping
module boid_addr_calc
  import boid_pkg::*;
#(
  parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
  parameter int ADDR_W       = $clog2(VIDEO_WIDTH*VIDEO_HEIGHT)+1
)(
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic [1:0]        dx,
  input  logic [1:0]        dy,
  output logic              in_bounds,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(VIDEO_WIDTH);
  localparam logic [ADDR_W-1:0] H_A = ADDR_W'(VIDEO_HEIGHT);

  logic [ADDR_W-1:0] px;
  logic [ADDR_W-1:0] py;

  // Widen before adding so sprites hanging off the edge are detected, not wrapped.
  assign px        = ADDR_W'(x) + ADDR_W'(dx);
  assign py        = ADDR_W'(y) + ADDR_W'(dy);
  assign in_bounds = (px < W_A) && (py < H_A);
  assign addr      = py * W_A + px;

endmodule

// File: rtl/boid_raster_writer.sv
// rtl/boid_raster_writer.sv - double-buffered boid sprite rasteriser into display RAM
module boid_raster_writer #(
  parameter int MAX_BOIDS    = 16,
  parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
  parameter int SPRITE_SIZE  = 2,
  localparam int BOID_W      = $clog2(MAX_BOIDS),
  localparam int ADDR_W      = $clog2(VIDEO_WIDTH*VIDEO_HEIGHT)+1
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [BOID_W-1:0] cpu_sel,
  input  logic [9:0]        cpu_x,
  input  logic [8:0]        cpu_y,
  input  logic              frame_end,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              clear_req,
  output logic              buf_sel,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  import boid_pkg::*;

  localparam logic [1:0]        SPR_MAX  = 2'(SPRITE_SIZE-1);
  localparam logic [BOID_W-1:0] BOID_MAX = BOID_W'(MAX_BOIDS-1);

  state_t            state;
  logic [9:0]        live_x   [MAX_BOIDS];
  logic [8:0]        live_y   [MAX_BOIDS];
  logic [9:0]        shadow_x [MAX_BOIDS];
  logic [8:0]        shadow_y [MAX_BOIDS];
  logic [BOID_W-1:0] idx;
  logic [1:0]        dx;
  logic [1:0]        dy;
  logic              draw_last;
  logic              pix_in_bounds;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_is_last;

  assign pix_is_last = (idx == BOID_MAX) && (dy == SPR_MAX) && (dx == SPR_MAX);

  boid_addr_calc #(
    .VIDEO_WIDTH (VIDEO_WIDTH),
    .VIDEO_HEIGHT(VIDEO_HEIGHT),
    .ADDR_W      (ADDR_W)
  ) u_addr_calc (
    .x        (shadow_x[idx]),
    .y        (shadow_y[idx]),
    .dx       (dx),
    .dy       (dy),
    .in_bounds(pix_in_bounds),
    .addr     (pix_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_BOIDS; i++) begin
        live_x[i] <= '0;
        live_y[i] <= '0;
      end
    end else if (cpu_we) begin
      live_x[cpu_sel] <= cpu_x;
      live_y[cpu_sel] <= cpu_y;
    end
  end

  // Outputs are registered one edge ahead: the counters name the pixel shown next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      clear_req <= 1'b0;
      buf_sel   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      idx       <= '0;
      dx        <= '0;
      dy        <= '0;
      draw_last <= 1'b0;
      for (int i = 0; i < MAX_BOIDS; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
      end
    end else begin
      clear_req <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      if (frame_end && state != ST_IDLE)
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (frame_end) begin
            state     <= ST_CLEAR;
            clear_req <= 1'b1;
            busy      <= 1'b1;
            buf_sel   <= ~buf_sel;
            for (int i = 0; i < MAX_BOIDS; i++) begin
              shadow_x[i] <= (cpu_we && cpu_sel == BOID_W'(i)) ? cpu_x : live_x[i];
              shadow_y[i] <= (cpu_we && cpu_sel == BOID_W'(i)) ? cpu_y : live_y[i];
            end
          end
        end
        ST_CLEAR, ST_DRAW: begin
          if (draw_last) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            draw_last <= 1'b0;
          end else begin
            state     <= ST_DRAW;
            wr_en     <= pix_in_bounds;
            wr_addr   <= pix_addr;
            draw_last <= pix_is_last;
            if (dx == SPR_MAX) begin
              dx <= '0;
              if (dy == SPR_MAX) begin
                dy  <= '0;
                idx <= idx + BOID_W'(1);
              end else begin
                dy <= dy + 2'd1;
              end
            end else begin
              dx <= dx + 2'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
